mem_access_ctrl: RTL and testbench

MEM_ACCESS_CTRL -- requirements
Module: mem_access_ctrl

---
 rtl/mem_access_ctrl_pkg.sv | 49 ++++
 rtl/mem_access_ctrl_if.sv | 34 +++
 rtl/mem_req_check.sv | 22 ++
 rtl/mem_access_ctrl.sv | 127 ++++++++++++
 tb/tb_mem_access_ctrl.sv | 339 +++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/mem_access_ctrl_pkg.sv
// Shared types and constants for the burst memory access controller.
// Holds the FSM state encoding, default geometry and the request-rejection rules.
package mem_access_ctrl_pkg;

    localparam int DATA_W            = 32;
    localparam int LEN_W             = 5;
    localparam int DEFAULT_MEM_WORDS = 1024;
    localparam int DEFAULT_MAX_LEN   = 16;

    typedef enum logic [2:0] {
        IDLE,
        WR,
        RD_ISSUE,
        RD_CAP,
        FIN
    } state_t;

    typedef enum logic [2:0] {
        CAUSE_NONE,
        CAUSE_ALIGN,
        CAUSE_LEN_ZERO,
        CAUSE_LEN_MAX,
        CAUSE_RANGE
    } err_cause_t;

    // The end-of-burst sum is one bit wider than a word index so it cannot overflow.
    function automatic err_cause_t classify_req(
        input logic [DATA_W-1:0] byte_addr,
        input logic [LEN_W-1:0]  len,
        input int                mem_words,
        input int                max_len
    );
        err_cause_t  cause;
        logic [32:0] end_word;
        end_word = {3'b000, byte_addr[31:2]} + {28'd0, len};
        if (byte_addr[1:0] != 2'b00)
            cause = CAUSE_ALIGN;
        else if (len == '0)
            cause = CAUSE_LEN_ZERO;
        else if ({27'd0, len} > 32'(max_len))
            cause = CAUSE_LEN_MAX;
        else if (end_word > 33'(mem_words))
            cause = CAUSE_RANGE;
        else
            cause = CAUSE_NONE;
        return cause;
    endfunction

endpackage

// File: rtl/mem_access_ctrl_if.sv
// Processor request/data channels plus the data-memory port of the controller.
// The slave modport is the controller's view; master is the processor/memory side.
interface mem_access_ctrl_if;
    import mem_access_ctrl_pkg::*;

    logic              req_valid;
    logic              req_ready;
    logic              req_wr;
    logic [DATA_W-1:0] req_addr;
    logic [LEN_W-1:0]  req_len;
    logic [DATA_W-1:0] wdata;
    logic              wvalid;
    logic              wready;
    logic [DATA_W-1:0] rdata;
    logic              rvalid;
    logic              done;
    logic              err;
    logic [DATA_W-1:0] addr;
    logic [DATA_W-1:0] data_in;
    logic              MemRd;
    logic              MemWr;
    logic [DATA_W-1:0] data_out;

    modport slave (
        input  req_valid, req_wr, req_addr, req_len, wdata, wvalid, data_out,
        output req_ready, wready, rdata, rvalid, done, err, addr, data_in, MemRd, MemWr
    );

    modport master (
        output req_valid, req_wr, req_addr, req_len, wdata, wvalid, data_out,
        input  req_ready, wready, rdata, rvalid, done, err, addr, data_in, MemRd, MemWr
    );

endinterface

// File: rtl/mem_req_check.sv
// Combinational validation of an incoming burst request.
// err is high when the request must be rejected without touching memory.
module mem_req_check
    import mem_access_ctrl_pkg::*;
#(
    parameter int MEM_WORDS = DEFAULT_MEM_WORDS,
    parameter int MAX_LEN   = DEFAULT_MAX_LEN
) (
    input  logic [DATA_W-1:0] req_addr,
    input  logic [LEN_W-1:0]  req_len,
    output logic              err
);

    err_cause_t cause;

    always_comb begin
        cause = classify_req(req_addr, req_len, MEM_WORDS, MAX_LEN);
    end

    assign err = (cause != CAUSE_NONE);

endmodule

// File: rtl/mem_access_ctrl.sv
// Burst read/write controller between a processor request port and a
// single-port data memory with one cycle of registered read latency.
module mem_access_ctrl
    import mem_access_ctrl_pkg::*;
#(
    parameter int MEM_WORDS = DEFAULT_MEM_WORDS,
    parameter int MAX_LEN   = DEFAULT_MAX_LEN
) (
    input logic              clk,
    input logic              rst_n,
    mem_access_ctrl_if.slave bus
);

    state_t            state;
    logic [DATA_W-1:0] word_idx;
    logic [LEN_W-1:0]  words_left;
    logic              req_ready_q;
    logic              wready_q;
    logic              rvalid_q;
    logic              done_q;
    logic              err_q;
    logic              mem_rd_q;
    logic [DATA_W-1:0] wdata_q;
    logic [DATA_W-1:0] rdata_q;
    logic              req_err;
    logic              wr_fire;

    mem_req_check #(
        .MEM_WORDS (MEM_WORDS),
        .MAX_LEN   (MAX_LEN)
    ) u_req_check (
        .req_addr (bus.req_addr),
        .req_len  (bus.req_len),
        .err      (req_err)
    );

    assign wr_fire = wready_q && bus.wvalid;

    // Every output flag is registered on entry to the state that owns it.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state       <= IDLE;
            word_idx    <= '0;
            words_left  <= '0;
            req_ready_q <= 1'b1;
            wready_q    <= 1'b0;
            rvalid_q    <= 1'b0;
            done_q      <= 1'b0;
            err_q       <= 1'b0;
            mem_rd_q    <= 1'b0;
            wdata_q     <= '0;
            rdata_q     <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (bus.req_valid) begin
                        word_idx    <= {2'b00, bus.req_addr[31:2]};
                        words_left  <= bus.req_len;
                        req_ready_q <= 1'b0;
                        if (req_err) begin
                            state  <= FIN;
                            done_q <= 1'b1;
                            err_q  <= 1'b1;
                        end else if (bus.req_wr) begin
                            state    <= WR;
                            wready_q <= 1'b1;
                        end else begin
                            state    <= RD_ISSUE;
                            mem_rd_q <= 1'b1;
                        end
                    end
                end
                WR: begin
                    if (bus.wvalid) begin
                        wdata_q    <= bus.wdata;
                        word_idx   <= word_idx + 32'd1;
                        words_left <= words_left - 5'd1;
                        if (words_left == 5'd1) begin
                            state    <= FIN;
                            wready_q <= 1'b0;
                            done_q   <= 1'b1;
                        end
                    end
                end
                RD_ISSUE: begin
                    mem_rd_q <= 1'b0;
                    rvalid_q <= 1'b1;
                    state    <= RD_CAP;
                end
                RD_CAP: begin
                    rvalid_q   <= 1'b0;
                    rdata_q    <= bus.data_out;
                    word_idx   <= word_idx + 32'd1;
                    words_left <= words_left - 5'd1;
                    if (words_left == 5'd1) begin
                        state  <= FIN;
                        done_q <= 1'b1;
                    end else begin
                        state    <= RD_ISSUE;
                        mem_rd_q <= 1'b1;
                    end
                end
                FIN: begin
                    done_q      <= 1'b0;
                    err_q       <= 1'b0;
                    req_ready_q <= 1'b1;
                    state       <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign bus.req_ready = req_ready_q;
    assign bus.wready    = wready_q;
    assign bus.rvalid    = rvalid_q;
    assign bus.done      = done_q;
    assign bus.err       = err_q;
    assign bus.addr      = word_idx;
    assign bus.MemRd     = mem_rd_q;
    assign bus.MemWr     = wr_fire;

    // Memory data arrives after the RD_ISSUE edge, so rdata passes it straight through while valid.
    assign bus.data_in = wr_fire ? bus.wdata : wdata_q;
    assign bus.rdata   = rvalid_q ? bus.data_out : rdata_q;

endmodule

// File: tb/tb_mem_access_ctrl.sv
// Self-checking bench for mem_access_ctrl: a cycle timeline of expected
// outputs is built from the burst rules and compared on every falling edge.
module tb_mem_access_ctrl;

    localparam int MEM_WORDS = 1024;
    localparam int MAX_LEN   = 16;

    logic clk = 1'b0;
    logic rst_n;

    mem_access_ctrl_if bus();

    mem_access_ctrl #(
        .MEM_WORDS (MEM_WORDS),
        .MAX_LEN   (MAX_LEN)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;
    int cyc = 0;
    bit rst_seen = 1'b0;
    bit check_en = 1'b0;
    int last_accept = 0;

    logic [31:0] mem [MEM_WORDS];
    logic [31:0] model_mem [MEM_WORDS];
    bit mem_ready = 1'b0;

    bit          exp_busy   [int];
    bit          exp_wready [int];
    bit          exp_memrd  [int];
    bit          exp_memwr  [int];
    bit          exp_rvalid [int];
    bit          exp_done   [int];
    bit          exp_err    [int];
    logic [31:0] exp_addr   [int];
    logic [31:0] exp_din    [int];
    logic [31:0] exp_rdata  [int];

    logic [31:0] obs_rdata [$];
    int          obs_rv_cyc [$];
    logic [31:0] obs_wr_addr [$];
    int obs_strobes = 0;
    int obs_done = 0;

    // Data memory as the top level would attach it: reads are registered.
    always @(posedge clk) begin
        if (!mem_ready) begin
            for (int i = 0; i < MEM_WORDS; i++) mem[i] <= i;
            mem_ready <= 1'b1;
        end else begin
            if (bus.MemWr) mem[bus.addr[9:0]] <= bus.data_in;
            if (bus.MemRd) bus.data_out <= mem[bus.addr[9:0]];
        end
    end

    always @(posedge clk) begin
        cyc      <= cyc + 1;
        rst_seen <= !rst_n;
        if (!rst_n) check_en <= 1'b1;
    end

    task automatic check_output(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s at cycle %0d: got 0x%0h, expected 0x%0h", name, cyc, act, exp);
        end
    endtask

    function automatic logic [31:0] flag(input bit b);
        return {31'd0, b};
    endfunction

    always @(negedge clk) begin
        if (check_en) begin
            check_output("rd_wr_exclusive", flag(bus.MemRd && bus.MemWr), 32'd0);
            if (rst_seen) begin
                check_output("rst_req_ready", flag(bus.req_ready), 32'd1);
                check_output("rst_wready", flag(bus.wready), 32'd0);
                check_output("rst_rvalid", flag(bus.rvalid), 32'd0);
                check_output("rst_done", flag(bus.done), 32'd0);
                check_output("rst_err", flag(bus.err), 32'd0);
                check_output("rst_memrd", flag(bus.MemRd), 32'd0);
                check_output("rst_memwr", flag(bus.MemWr), 32'd0);
                check_output("rst_addr", bus.addr, 32'd0);
                check_output("rst_data_in", bus.data_in, 32'd0);
                check_output("rst_rdata", bus.rdata, 32'd0);
            end else begin
                check_output("req_ready", flag(bus.req_ready), flag(!exp_busy.exists(cyc)));
                check_output("wready", flag(bus.wready), flag(exp_wready.exists(cyc)));
                check_output("memrd", flag(bus.MemRd), flag(exp_memrd.exists(cyc)));
                check_output("memwr", flag(bus.MemWr), flag(exp_memwr.exists(cyc)));
                check_output("rvalid", flag(bus.rvalid), flag(exp_rvalid.exists(cyc)));
                check_output("done", flag(bus.done), flag(exp_done.exists(cyc)));
                check_output("err", flag(bus.err), flag(exp_err.exists(cyc)));
                if (exp_addr.exists(cyc)) check_output("addr", bus.addr, exp_addr[cyc]);
                if (exp_din.exists(cyc)) check_output("data_in", bus.data_in, exp_din[cyc]);
                if (exp_rdata.exists(cyc)) check_output("rdata", bus.rdata, exp_rdata[cyc]);
            end
            if (bus.rvalid) begin
                obs_rdata.push_back(bus.rdata);
                obs_rv_cyc.push_back(cyc);
            end
            if (bus.MemWr) obs_wr_addr.push_back(bus.addr);
            if (bus.MemRd || bus.MemWr) obs_strobes++;
            if (bus.done) obs_done++;
        end
    end

    function automatic bit model_err(input logic [31:0] a, input int len);
        longint first_word;
        first_word = longint'(a) / 4;
        return (a % 4 != 0) || (len < 1) || (len > MAX_LEN) || (first_word + len > MEM_WORDS);
    endfunction

    function automatic void purge(input int from);
        for (int k = from; k < from + 100; k++) begin
            exp_busy.delete(k);   exp_wready.delete(k); exp_memrd.delete(k);
            exp_memwr.delete(k);  exp_rvalid.delete(k); exp_done.delete(k);
            exp_err.delete(k);    exp_addr.delete(k);   exp_din.delete(k);
            exp_rdata.delete(k);
        end
    endfunction

    function automatic void schedule_read(input int c, input int base, input int len);
        for (int k = 0; k < len; k++) begin
            exp_memrd[c + 1 + 2*k]  = 1'b1;
            exp_addr[c + 1 + 2*k]   = 32'(base + k);
            exp_rvalid[c + 2 + 2*k] = 1'b1;
            exp_rdata[c + 2 + 2*k]  = model_mem[base + k];
        end
        exp_done[c + 2*len + 1] = 1'b1;
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_cycles(input int n);
        repeat (n) begin
            step();
            bus.wvalid = 1'($urandom_range(0, 1));
            bus.wdata  = $urandom;
        end
    endtask

    // Issues one request in the current (idle) cycle and runs it to completion;
    // wpat != 0 gives a fixed wvalid pattern with data wbase, wbase+1, ...
    task automatic apply_stimulus(input bit wr, input logic [31:0] a, input int len,
                                  input logic [31:0] wpat, input logic [31:0] wbase);
        int c, t, endc, base, rem, hs, j;
        bit e, wv;
        logic [31:0] d;
        c = cyc;
        last_accept = c;
        bus.req_valid = 1'b1;
        bus.req_wr    = wr;
        bus.req_addr  = a;
        bus.req_len   = 5'(len);
        e    = model_err(a, len);
        base = e ? 0 : int'(a >> 2);
        rem  = len;
        hs   = 0;
        j    = 0;
        t    = c;
        if (e) begin
            endc = c + 1;
            exp_done[endc] = 1'b1;
            exp_err[endc]  = 1'b1;
        end else if (!wr) begin
            schedule_read(c, base, len);
            endc = c + 2*len + 1;
        end else begin
            endc = c + 100000;
        end
        while (t <= endc) begin
            step();
            t = cyc;
            bus.req_valid = ($urandom_range(0, 3) == 0);
            bus.req_wr    = 1'($urandom_range(0, 1));
            bus.req_addr  = $urandom;
            bus.req_len   = 5'($urandom_range(0, 31));
            if (wr && !e && rem > 0) begin
                exp_wready[t] = 1'b1;
                wv = (wpat != 0) ? wpat[j] : ($urandom_range(0, 2) != 0);
                d  = (wpat != 0) ? wbase + 32'(hs) : $urandom;
                j++;
                if (wv) begin
                    exp_memwr[t] = 1'b1;
                    exp_addr[t]  = 32'(base + hs);
                    exp_din[t]   = d;
                    model_mem[base + hs] = d;
                    hs++;
                    rem--;
                    if (rem == 0) begin
                        endc = t + 1;
                        exp_done[endc] = 1'b1;
                    end
                end
                bus.wvalid = wv;
                bus.wdata  = d;
            end else begin
                bus.wvalid = 1'($urandom_range(0, 1));
                bus.wdata  = $urandom;
            end
            if (t <= endc) exp_busy[t] = 1'b1;
        end
        bus.req_valid = 1'b0;
        bus.wvalid    = 1'b0;
    endtask

    // Starts a 4-word read and pulls reset while word 2 is being issued.
    task automatic reset_mid_read(input logic [31:0] a);
        int c;
        c = cyc;
        bus.req_valid = 1'b1;
        bus.req_wr    = 1'b0;
        bus.req_addr  = a;
        bus.req_len   = 5'd4;
        schedule_read(c, int'(a >> 2), 4);
        repeat (3) begin
            step();
            bus.req_valid = 1'b0;
            exp_busy[cyc] = 1'b1;
        end
        rst_n = 1'b0;
        purge(cyc + 1);
        repeat (2) step();
        rst_n = 1'b1;
    endtask

    initial begin
        #500000;
        $display("[TB] FAIL watchdog: simulation did not finish, cycle %0d", cyc);
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        int n0, nw, s0, d0, len;
        logic [31:0] a;
        bit wr;
        logic [31:0] err_addr [4];
        int          err_len  [4];

        for (int i = 0; i < MEM_WORDS; i++) model_mem[i] = i;
        rst_n         = 1'b0;
        bus.req_valid = 1'b0;
        bus.req_wr    = 1'b0;
        bus.req_addr  = '0;
        bus.req_len   = '0;
        bus.wvalid    = 1'b0;
        bus.wdata     = '0;
        repeat (3) step();
        rst_n = 1'b1;
        step();

        n0 = obs_rdata.size();
        apply_stimulus(1'b0, 32'h10, 1, 32'd0, 32'd0);
        check_output("model_mem_init", model_mem[4], 32'd4);
        check_output("rd1_count", 32'(obs_rdata.size() - n0), 32'd1);
        if (obs_rdata.size() > n0) begin
            check_output("rd1_data", obs_rdata[n0], 32'd4);
            check_output("rd1_latency", 32'(obs_rv_cyc[n0] - last_accept), 32'd2);
        end
        idle_cycles(1);

        nw = obs_wr_addr.size();
        apply_stimulus(1'b1, 32'h40, 3, 32'b1101, 32'hA);
        check_output("model_mem_write", model_mem[17], 32'hB);
        check_output("wr_count", 32'(obs_wr_addr.size() - nw), 32'd3);
        for (int k = 0; k < 3; k++)
            if (obs_wr_addr.size() > nw + k)
                check_output("wr_addr", obs_wr_addr[nw + k], 32'(16 + k));
        n0 = obs_rdata.size();
        apply_stimulus(1'b0, 32'h40, 3, 32'd0, 32'd0);
        check_output("readback_count", 32'(obs_rdata.size() - n0), 32'd3);
        for (int k = 0; k < 3; k++)
            if (obs_rdata.size() > n0 + k)
                check_output("readback_data", obs_rdata[n0 + k], 32'(32'hA + k));

        err_addr = '{32'h2, 32'h0, 32'h0, 32'hFFC};
        err_len  = '{1, 0, 17, 2};
        s0 = obs_strobes;
        d0 = obs_done;
        for (int i = 0; i < 4; i++) begin
            check_output("err_model", flag(model_err(err_addr[i], err_len[i])), 32'd1);
            apply_stimulus(1'(i % 2), err_addr[i], err_len[i], 32'd0, 32'd0);
        end
        check_output("err_no_strobes", 32'(obs_strobes - s0), 32'd0);
        check_output("err_done_count", 32'(obs_done - d0), 32'd4);

        n0 = obs_rdata.size();
        d0 = obs_done;
        apply_stimulus(1'b0, 32'hFC0, 16, 32'd0, 32'd0);
        check_output("top_count", 32'(obs_rdata.size() - n0), 32'd16);
        for (int k = 0; k < 16; k++)
            if (obs_rdata.size() > n0 + k)
                check_output("top_data", obs_rdata[n0 + k], 32'(1008 + k));
        check_output("top_done", 32'(obs_done - d0), 32'd1);

        n0 = obs_rdata.size();
        d0 = obs_done;
        reset_mid_read(32'h80);
        apply_stimulus(1'b0, 32'h80, 2, 32'd0, 32'd0);
        check_output("rst_mid_done", 32'(obs_done - d0), 32'd1);
        check_output("rst_mid_count", 32'(obs_rdata.size() - n0), 32'd3);
        if (obs_rdata.size() >= n0 + 3) begin
            check_output("rst_mid_word0", obs_rdata[n0], 32'd32);
            check_output("rst_mid_new0", obs_rdata[n0 + 1], 32'd32);
            check_output("rst_mid_new1", obs_rdata[n0 + 2], 32'd33);
        end

        for (int i = 0; i < 40; i++) begin
            wr  = 1'($urandom_range(0, 1));
            len = $urandom_range(0, 17);
            case ($urandom_range(0, 9))
                0:       a = $urandom;
                1:       a = 32'($urandom_range(0, 1023) * 4 + $urandom_range(1, 3));
                2:       a = 32'((MEM_WORDS - len) * 4);
                default: a = 32'($urandom_range(0, 1023) * 4);
            endcase
            apply_stimulus(wr, a, len, 32'd0, 32'd0);
            idle_cycles($urandom_range(0, 2));
        end

        idle_cycles(2);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
